// File: rtl/uart_tx_word.sv
// UART transmitter for the 16-bit word link: sends one word as two 11-bit frames
// (start, byte number, 8 data bits LSB first, stop), low byte first.
module uart_tx_word #(
  parameter int CLKS_PER_BIT = 521,
  parameter int GAP_BITS     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [15:0] word,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    BYTE_NUM = 3'd2,
    DATA     = 3'd3,
    STOP     = 3'd4,
    GAP      = 3'd5,
    COMPLETE = 3'd6
  } state_t;

  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_GAP = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_t      state_reg, state_next;
  logic [15:0] shadow_reg, shadow_next;
  logic        byte_sel_reg, byte_sel_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic [15:0] clk_count_reg, clk_count_next;
  logic        tx_reg, tx_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        bit_end;

  assign bit_end = (clk_count_reg == LAST_CLK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      shadow_reg    <= '0;
      byte_sel_reg  <= 1'b0;
      bit_idx_reg   <= '0;
      gap_cnt_reg   <= '0;
      clk_count_reg <= '0;
      tx_reg        <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shadow_reg    <= shadow_next;
      byte_sel_reg  <= byte_sel_next;
      bit_idx_reg   <= bit_idx_next;
      gap_cnt_reg   <= gap_cnt_next;
      clk_count_reg <= clk_count_next;
      tx_reg        <= tx_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shadow_next    = shadow_reg;
    byte_sel_next  = byte_sel_reg;
    bit_idx_next   = bit_idx_reg;
    gap_cnt_next   = gap_cnt_reg;
    clk_count_next = clk_count_reg + 16'd1;

    case (state_reg)
      IDLE: begin
        clk_count_next = '0;
        if (send) begin
          shadow_next   = word;
          byte_sel_next = 1'b0;
          bit_idx_next  = '0;
          gap_cnt_next  = '0;
          state_next    = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_count_next = '0;
          state_next     = BYTE_NUM;
        end
      end
      BYTE_NUM: begin
        if (bit_end) begin
          clk_count_next = '0;
          bit_idx_next   = '0;
          state_next     = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_count_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_count_next = '0;
          if (!byte_sel_reg) begin
            byte_sel_next = 1'b1;
            bit_idx_next  = '0;
            state_next    = (GAP_BITS > 0) ? GAP : START;
          end else begin
            state_next = COMPLETE;
          end
        end
      end
      GAP: begin
        // gap length counted in whole bit times on its own counter
        if (bit_end) begin
          clk_count_next = '0;
          if (gap_cnt_reg == LAST_GAP) begin
            gap_cnt_next = '0;
            state_next   = START;
          end else begin
            gap_cnt_next = gap_cnt_reg + 4'd1;
          end
        end
      end
      COMPLETE: begin
        clk_count_next = '0;
        state_next     = IDLE;
      end
      default: begin
        clk_count_next = '0;
        state_next     = IDLE;
      end
    endcase

    // Outputs are registered from the next state so each bit appears on the
    // edge that enters its state.
    case (state_next)
      START:    tx_next = 1'b0;
      BYTE_NUM: tx_next = byte_sel_next;
      DATA:     tx_next = shadow_next[{byte_sel_next, bit_idx_next}];
      default:  tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == COMPLETE);
  end

  assign tx    = tx_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: three instances (16/1, 2/0, 521/1) checked every cycle
// against a frame-arithmetic model, plus directed frame captures with literal values.
module tb_uart_tx_word;

  localparam int CPB_T [3] = '{16, 2, 521};
  localparam int GAP_T [3] = '{1, 0, 1};

  logic        clk;
  logic        rst;
  logic [2:0]  send_w;
  logic [15:0] word_w [3];
  logic [2:0]  tx_w, busy_w, done_w;
  logic [2:0]  state_w [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int busy_cnt [3];
  int done_cnt [3];
  int last_done_cyc [3];

  logic        m_act [3];
  int          m_pos [3];
  logic [15:0] m_word [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_inst
      uart_tx_word #(
        .CLKS_PER_BIT(CPB_T[gi]),
        .GAP_BITS    (GAP_T[gi])
      ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .send (send_w[gi]),
        .word (word_w[gi]),
        .tx   (tx_w[gi]),
        .busy (busy_w[gi]),
        .done (done_w[gi]),
        .state(state_w[gi])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int total_cyc(input int i);
    return (22 + GAP_T[i]) * CPB_T[i];
  endfunction

  // Line level for bit-time b of a word transfer, from the frame layout.
  function automatic logic exp_tx(input logic [15:0] w, input int b, input int gap);
    int  j;
    logic [7:0] d;
    logic bn;
    if (b < 11) begin
      j = b; d = w[7:0]; bn = 1'b0;
    end else if (b < 11 + gap) begin
      return 1'b1;
    end else begin
      j = b - 11 - gap; d = w[15:8]; bn = 1'b1;
    end
    if (j == 0) return 1'b0;
    if (j == 1) return bn;
    if (j <= 9) return d[j-2];
    return 1'b1;
  endfunction

  // Model: position in the transfer, advanced once per clock.
  initial begin
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_pos[i] = 0; m_word[i] = '0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          m_act[i] = 1'b0;
          m_pos[i] = 0;
        end else if (m_act[i]) begin
          if (m_pos[i] == total_cyc(i)) m_act[i] = 1'b0;
          else m_pos[i] = m_pos[i] + 1;
        end else if (send_w[i]) begin
          m_act[i]  = 1'b1;
          m_pos[i]  = 0;
          m_word[i] = word_w[i];
        end
      end
    end
  end

  // Per-cycle comparison and activity counters.
  initial begin
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; last_done_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        logic e_tx, e_busy, e_done;
        if (!m_act[i]) begin
          e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        end else if (m_pos[i] < total_cyc(i)) begin
          e_tx = exp_tx(m_word[i], m_pos[i] / CPB_T[i], GAP_T[i]);
          e_busy = 1'b1; e_done = 1'b0;
        end else begin
          e_tx = 1'b1; e_busy = 1'b1; e_done = 1'b1;
        end
        chk($sformatf("model_tx[%0d]", i), 32'(tx_w[i]), 32'(e_tx));
        chk($sformatf("model_busy[%0d]", i), 32'(busy_w[i]), 32'(e_busy));
        chk($sformatf("model_done[%0d]", i), 32'(done_w[i]), 32'(e_done));
        if (!m_act[i]) chk($sformatf("model_state_idle[%0d]", i), 32'(state_w[i]), 32'd0);
        else if (e_done) chk($sformatf("model_state_complete[%0d]", i), 32'(state_w[i]), 32'd6);
        if (busy_w[i] === 1'b1) busy_cnt[i]++;
        if (done_w[i] === 1'b1) begin
          done_cnt[i]++;
          last_done_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Capture one frame at mid-bit; f[0] is the start bit, f[10] the stop bit.
  task automatic rx_frame(input int idx, output logic [10:0] f, output int fall);
    int n;
    n = 0;
    f = '1;
    while (tx_w[idx] !== 1'b0 && n < 40 * CPB_T[idx]) begin
      tick(1);
      n++;
    end
    chk($sformatf("rx_start[%0d]", idx), 32'(tx_w[idx]), 32'd0);
    fall = cyc;
    tick(CPB_T[idx] / 2);
    f[0] = tx_w[idx];
    for (int j = 1; j < 11; j++) begin
      tick(CPB_T[idx]);
      f[j] = tx_w[idx];
    end
    $display("tx[%0d] frame captured %03h (start cycle %0d)", idx, f, fall);
  endtask

  task automatic pulse_send(input int idx, input logic [15:0] w);
    word_w[idx] = w;
    send_w[idx] = 1'b1;
    tick(1);
    send_w[idx] = 1'b0;
  endtask

  initial begin
    logic [10:0] f, g;
    logic [15:0] rx_word;
    int fa, fb, k, b0, d0;

    rst = 1'b1;
    send_w = '0;
    for (int i = 0; i < 3; i++) word_w[i] = '0;
    tick(3);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx", 32'(tx_w[i]), 32'd1);
      chk("reset_busy", 32'(busy_w[i]), 32'd0);
      chk("reset_done", 32'(done_w[i]), 32'd0);
      chk("reset_state", 32'(state_w[i]), 32'd0);
    end

    // 1: single word A53C, CLKS_PER_BIT=16, one gap bit
    b0 = busy_cnt[0]; d0 = done_cnt[0];
    k = cyc;
    pulse_send(0, 16'hA53C);
    rx_frame(0, f, fa);
    chk("t1_frame0", 32'(f), 32'h4F0);
    rx_frame(0, f, fb);
    chk("t1_frame1", 32'(f), 32'h696);
    chk("t1_frame_spacing", 32'(fb - fa), 32'd192);
    tick(24);
    chk("t1_done_pulses", 32'(done_cnt[0] - d0), 32'd1);
    chk("t1_done_cycle", 32'(last_done_cyc[0] - k), 32'd369);
    chk("t1_busy_cycles", 32'(busy_cnt[0] - b0), 32'd369);

    // 2: send held high, 0001 then FFFF back to back
    d0 = done_cnt[0];
    word_w[0] = 16'h0001;
    send_w[0] = 1'b1;
    tick(1);
    rx_frame(0, f, fa);
    chk("t2_w0_frame0", 32'(f), 32'h404);
    word_w[0] = 16'hFFFF;
    rx_frame(0, f, fa);
    chk("t2_w0_frame1", 32'(f), 32'h402);
    rx_frame(0, f, fb);
    send_w[0] = 1'b0;
    chk("t2_w1_frame0", 32'(f), 32'h7FC);
    chk("t2_word_spacing", 32'(fb - fa), 32'd178);
    rx_frame(0, f, fa);
    chk("t2_w1_frame1", 32'(f), 32'h7FE);
    tick(24);
    chk("t2_done_pulses", 32'(done_cnt[0] - d0), 32'd2);

    // 3: word input changes during frame 0 of a BEEF transfer
    pulse_send(0, 16'hBEEF);
    fork
      rx_frame(0, f, fa);
      begin
        tick(40);
        word_w[0] = 16'h1234;
      end
    join
    chk("t3_frame0", 32'(f), 32'h7BC);
    rx_frame(0, f, fb);
    chk("t3_frame1", 32'(f), 32'h6FA);
    tick(24);

    // 4: reset during data bit 4 of frame 1, then a clean 00FF transfer
    d0 = done_cnt[0];
    pulse_send(0, 16'hA53C);
    rx_frame(0, f, fa);
    chk("t4_frame0", 32'(f), 32'h4F0);
    while (cyc < fa + 192 + 100) tick(1);
    chk("t4_tx_before_rst", 32'(tx_w[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("t4_rst_tx", 32'(tx_w[0]), 32'd1);
    chk("t4_rst_state", 32'(state_w[0]), 32'd0);
    chk("t4_rst_busy", 32'(busy_w[0]), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(30);
    chk("t4_no_done", 32'(done_cnt[0] - d0), 32'd0);
    pulse_send(0, 16'h00FF);
    rx_frame(0, f, fa);
    chk("t4_after_frame0", 32'(f), 32'h7FC);
    rx_frame(0, f, fa);
    chk("t4_after_frame1", 32'(f), 32'h402);
    tick(24);

    // 5: CLKS_PER_BIT=2, no gap
    b0 = busy_cnt[1]; d0 = done_cnt[1];
    pulse_send(1, 16'hA53C);
    rx_frame(1, f, fa);
    chk("t5_frame0", 32'(f), 32'h4F0);
    rx_frame(1, f, fb);
    chk("t5_frame1", 32'(f), 32'h696);
    chk("t5_frame_spacing", 32'(fb - fa), 32'd22);
    tick(6);
    chk("t5_busy_cycles", 32'(busy_cnt[1] - b0), 32'd45);
    chk("t5_done_pulses", 32'(done_cnt[1] - d0), 32'd1);

    // 6: 521 clocks per bit, frames decoded back into a word
    d0 = done_cnt[2];
    pulse_send(2, 16'h1F40);
    rx_frame(2, f, fa);
    rx_frame(2, g, fb);
    rx_word = '0;
    if (f[1]) rx_word[15:8] = f[9:2]; else rx_word[7:0] = f[9:2];
    if (g[1]) rx_word[15:8] = g[9:2]; else rx_word[7:0] = g[9:2];
    chk("t6_byte_num0", 32'(f[1]), 32'd0);
    chk("t6_byte_num1", 32'(g[1]), 32'd1);
    chk("t6_stop_bits", 32'({f[10], g[10]}), 32'd3);
    chk("t6_rx_word", 32'(rx_word), 32'h1F40);
    tick(600);
    chk("t6_done_pulses", 32'(done_cnt[2] - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
